// File: rtl/sparse_pack_encoder.sv
// sparse_pack_encoder: drops zero matrix elements from a dense (matrix, vector)
// pair stream and packs the kept pairs into K-lane beats with an IPV
// row-boundary mask. A single output register holds the beat.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and its payload stable until that edge, and
// ready never depends on valid of the same side.
module sparse_pack_encoder #(
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_mat,
  input  logic [7:0]     in_vec,
  input  logic           in_row_end,
  input  logic           in_last,
  output logic [8*K-1:0] matrix_out,
  output logic [8*K-1:0] vector_out,
  output logic [K-1:0]   IPV,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           done
);

  localparam int CW = $clog2(K + 1);

  logic [7:0]    mat_buf [K];
  logic [7:0]    vec_buf [K];
  logic [K-1:0]  bnd_buf;
  logic [CW-1:0] cnt;
  logic          flush_pending;

  logic          group_ready;
  logic          transfer;
  logic          accept;
  logic          keep;
  logic          row_end;
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] cnt_base;
  logic [8*K-1:0] pack_mat;
  logic [8*K-1:0] pack_vec;
  logic [K-1:0]   pack_ipv;

  // Handshake and control decode. in_last alone is treated as a row end.
  always_comb begin
    row_end     = in_row_end || in_last;
    group_ready = (cnt == CW'(K)) || flush_pending;
    transfer    = group_ready && (!out_valid || out_ready);
    in_ready    = rst && !flush_pending && ((cnt < CW'(K)) || transfer);
    accept      = in_valid && in_ready;
    keep        = (in_mat != 8'd0) || row_end;
    cnt_base    = transfer ? '0 : cnt;
    wr_idx      = cnt_base;
  end

  // Build the outgoing beat: slots 0..cnt-1 map to lanes, unused lanes stay zero.
  always_comb begin
    pack_mat = '0;
    pack_vec = '0;
    pack_ipv = '0;
    for (int i = 0; i < K; i++) begin
      if (CW'(i) < cnt) begin
        pack_mat[8*(K-1-i) +: 8] = mat_buf[i];
        pack_vec[8*(K-1-i) +: 8] = vec_buf[i];
        pack_ipv[K-1-i]          = bnd_buf[i];
      end
    end
  end

  // Pack buffer, fill count and flush flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < K; i++) begin
        mat_buf[i] <= '0;
        vec_buf[i] <= '0;
      end
      bnd_buf       <= '0;
      cnt           <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (accept && keep) begin
        for (int i = 0; i < K; i++) begin
          if (wr_idx == CW'(i)) begin
            mat_buf[i] <= in_mat;
            vec_buf[i] <= in_vec;
            bnd_buf[i] <= row_end;
          end
        end
        cnt <= cnt_base + CW'(1);
      end else begin
        cnt <= cnt_base;
      end
      if (accept && in_last) begin
        flush_pending <= 1'b1;
      end else if (transfer) begin
        flush_pending <= 1'b0;
      end
    end
  end

  // Output register: load on transfer, clear to an all-zero idle bus once consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      matrix_out <= '0;
      vector_out <= '0;
      IPV        <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else if (transfer) begin
      matrix_out <= pack_mat;
      vector_out <= pack_vec;
      IPV        <= pack_ipv;
      out_valid  <= 1'b1;
      out_last   <= flush_pending;
    end else if (out_valid && out_ready) begin
      matrix_out <= '0;
      vector_out <= '0;
      IPV        <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end
  end

  // One-cycle completion pulse after the final beat is consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= out_valid && out_ready && out_last;
    end
  end

endmodule
